perceptron_weight_bank: RTL and testbench

- Parametrised weight/bias store and training engine for a single-layer perceptron neuron. Generalises the single-register-per-weight update to configurable width, fixed-point scaling, saturation, a valid/ready training handshake and direct weight load.
- Sits beside the neuron's dot-product/activation datapath; exposes all weights and the bias continuously and applies one perceptron learning step per accepted training sample, sequentially, one weight per cycle.

---
 rtl/perceptron_weight_bank_if.sv | 43 ++++
 rtl/perceptron_weight_bank.sv | 174 +++++++++++++++++
 tb/tb_perceptron_weight_bank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/perceptron_weight_bank_if.sv
// perceptron_weight_bank_if
//   Bundles the training handshake, direct-load port and the weight/bias
//   outputs of perceptron_weight_bank.
//   master : drives the training sample and load requests, observes state
//   slave  : the weight bank itself
//   Signals:
//     train_valid/train_ready  training handshake (accept = valid & ready)
//     x, expected_y, y, learning_rate  training sample
//     load_en/load_addr/load_data      direct register write (addr N = bias)
//     weights, bias                    current register contents
//     busy, done, sat                  engine status
interface perceptron_weight_bank_if #(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int AW = $clog2(N + 1)
) ();
  logic              train_valid;
  logic              train_ready;
  logic [N-1:0]      x;
  logic [W-1:0]      expected_y;
  logic [W-1:0]      y;
  logic [W-1:0]      learning_rate;
  logic              load_en;
  logic [AW-1:0]     load_addr;
  logic [W-1:0]      load_data;
  logic [W*N-1:0]    weights;
  logic [W-1:0]      bias;
  logic              busy;
  logic              done;
  logic              sat;

  modport master (
    output train_valid, x, expected_y, y, learning_rate,
    output load_en, load_addr, load_data,
    input  train_ready, weights, bias, busy, done, sat
  );

  modport slave (
    input  train_valid, x, expected_y, y, learning_rate,
    input  load_en, load_addr, load_data,
    output train_ready, weights, bias, busy, done, sat
  );
endinterface

// File: rtl/perceptron_weight_bank.sv
// perceptron_weight_bank
//   Weight/bias store and sequential perceptron training engine. One accepted
//   sample produces adj = sat((expected_y - y) * learning_rate >>> FRAC),
//   then adds adj to each weight whose input bit is set (one per cycle) and
//   finally to the bias, all with saturating arithmetic.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  perceptron_weight_bank_if.slave (handshake, load port, outputs)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | ready for a sample; direct loads are applied here only
//   S_CALC   | compute and register the saturated adjustment
//   S_UPDATE | walk weights 0..N-1, adding adj where x[index] is set
//   S_BIAS   | add adj to the bias
//   S_DONE   | one-cycle completion pulse
module perceptron_weight_bank #(
  parameter int N    = 8,
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int AW   = $clog2(N + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  perceptron_weight_bank_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] ADDR_BIAS = AW'(N);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_UPDATE,
    S_BIAS,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [N-1:0]    r_x;
  logic [W-1:0]    r_ey;
  logic [W-1:0]    r_y;
  logic [W-1:0]    r_lr;
  logic [W-1:0]    r_adj;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_weights [N];
  logic [W-1:0]    r_bias;
  logic            r_sat;

  logic            w_accept;
  logic [W:0]      w_delta;
  logic [2*W:0]    w_delta_x;
  logic [2*W:0]    w_lr_x;
  logic [2*W:0]    w_prod;
  logic [2*W:0]    w_shift;
  logic [W:0]      w_hi;
  logic            w_adj_ovf;
  logic [W-1:0]    w_adj;
  logic [W:0]      w_wsum;
  logic [W:0]      w_bsum;

  // Returns {overflow, clamped sum} of two W-bit signed values.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1]) begin
      return {1'b1, sum[W], {(W-1){~sum[W]}}};
    end
    return {1'b0, sum[W-1:0]};
  endfunction

  assign w_accept = bus.train_valid && (r_state == S_IDLE);

  // Operands are explicitly sign-extended to the full product width so the
  // truncated multiply is exact for every signed input combination.
  always_comb begin
    w_delta   = {r_ey[W-1], r_ey} - {r_y[W-1], r_y};
    w_delta_x = {{W{w_delta[W]}}, w_delta};
    w_lr_x    = {{(W+1){r_lr[W-1]}}, r_lr};
    w_prod    = w_delta_x * w_lr_x;
    w_shift   = $unsigned($signed(w_prod) >>> FRAC);
    // In range only when every bit from the sign down to bit W-1 agrees.
    w_hi      = w_shift[2*W:W-1];
    w_adj_ovf = !((&w_hi) || !(|w_hi));
    if (w_adj_ovf) begin
      w_adj = {w_shift[2*W], {(W-1){~w_shift[2*W]}}};
    end else begin
      w_adj = w_shift[W-1:0];
    end
    w_wsum = sat_add(r_weights[r_idx], r_adj);
    w_bsum = sat_add(r_bias, r_adj);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_CALC;
      S_CALC:   w_next_state = (w_adj == '0) ? S_DONE : S_UPDATE;
      S_UPDATE: if (r_idx == IDX_LAST) w_next_state = S_BIAS;
      S_BIAS:   w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_ey    <= '0;
      r_y     <= '0;
      r_lr    <= '0;
      r_adj   <= '0;
      r_idx   <= '0;
      r_bias  <= '0;
      r_sat   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_weights[i] <= '0;
      end
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x   <= bus.x;
            r_ey  <= bus.expected_y;
            r_y   <= bus.y;
            r_lr  <= bus.learning_rate;
            r_sat <= 1'b0;
          end else if (bus.load_en) begin
            // Addresses above the bias slot are silently dropped.
            if (bus.load_addr < ADDR_BIAS) begin
              r_weights[bus.load_addr[IW-1:0]] <= bus.load_data;
            end else if (bus.load_addr == ADDR_BIAS) begin
              r_bias <= bus.load_data;
            end
          end
        end
        S_CALC: begin
          r_adj <= w_adj;
          r_sat <= w_adj_ovf;
          r_idx <= '0;
        end
        S_UPDATE: begin
          if (r_x[r_idx]) begin
            r_weights[r_idx] <= w_wsum[W-1:0];
            if (w_wsum[W]) r_sat <= 1'b1;
          end
          r_idx <= r_idx + 1'b1;
        end
        S_BIAS: begin
          r_bias <= w_bsum[W-1:0];
          if (w_bsum[W]) r_sat <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_wout
    assign bus.weights[W*g +: W] = r_weights[g];
  end

  assign bus.bias        = r_bias;
  assign bus.sat         = r_sat;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.train_ready = (r_state == S_IDLE);
  assign bus.done        = (r_state == S_DONE);

endmodule

// File: tb/tb_perceptron_weight_bank.sv
module tb_perceptron_weight_bank;
  localparam int N = 8, W = 16, FRAC = 8, AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perceptron_weight_bank_if #(.N(N), .W(W), .AW(AW)) bus ();

  perceptron_weight_bank #(.N(N), .W(W), .FRAC(FRAC), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W*N-1:0] w;
    logic [W-1:0]   b;
    logic           s;
    int             cyc;
    string          name;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.busy) chk("ready_low_when_busy", bus.train_ready, 1'b0);
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_weights"}, bus.weights, e.w);
        chk({e.name, "_bias"}, bus.bias, e.b);
        chk({e.name, "_sat"}, bus.sat, e.s);
        chk({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_reset(input string name);
    chk({name, "_weights"}, bus.weights, '0);
    chk({name, "_bias"}, bus.bias, '0);
    chk({name, "_sat"}, bus.sat, 1'b0);
    chk({name, "_ready"}, bus.train_ready, 1'b1);
    chk({name, "_busy"}, bus.busy, 1'b0);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic train(input string name, input logic [N-1:0] xv, input logic [W-1:0] ey,
                       input logic [W-1:0] yv, input logic [W-1:0] lr,
                       input logic [W*N-1:0] ew, input logic [W-1:0] eb, input logic es,
                       input int lat, input logic ld_same, input logic ld_busy);
    exp_t e;
    @(negedge clk);
    bus.train_valid = 1'b1; bus.x = xv; bus.expected_y = ey; bus.y = yv; bus.learning_rate = lr;
    if (ld_same) begin
      bus.load_en = 1'b1; bus.load_addr = 4'd3; bus.load_data = 16'h1234;
    end
    @(posedge clk); #1;
    e.w = ew; e.b = eb; e.s = es; e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    // Disturb the sample inputs; the engine must use the latched copy.
    bus.train_valid = 1'b0; bus.load_en = 1'b0;
    bus.x = ~xv; bus.expected_y = yv; bus.y = ey; bus.learning_rate = 16'h7FFF;
    if (ld_busy) begin
      @(negedge clk);
      bus.load_en = 1'b1; bus.load_addr = 4'd4; bus.load_data = 16'h5555;
      repeat (3) @(negedge clk);
      bus.load_en = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    bus.train_valid = 0; bus.x = '0; bus.expected_y = '0; bus.y = '0; bus.learning_rate = '0;
    bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset_initial");

    // weights listed w7..w0
    train("basic", 8'b0000_0101, 16'h0100, 16'h0000, 16'h0080,
          {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0, 16'h0080},
          16'h0080, 1'b0, 10, 1'b0, 1'b0);

    load(4'd1, 16'h0200);
    train("negative", 8'b0000_0010, 16'h0000, 16'h0100, 16'h0100,
          {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0100, 16'h0080},
          16'hFF80, 1'b0, 10, 1'b0, 1'b0);

    load(4'd0, 16'h7F00);
    train("saturate", 8'b0000_0001, 16'h7FFF, 16'h8000, 16'h7FFF,
          {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0100, 16'h7FFF},
          16'h7F7F, 1'b1, 10, 1'b0, 1'b0);

    train("zero_delta", 8'hFF, 16'h0100, 16'h0100, 16'h0100,
          {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0100, 16'h7FFF},
          16'h7F7F, 1'b0, 1, 1'b0, 1'b0);

    train("accept_beats_load", 8'b0000_0100, 16'h0200, 16'h0100, 16'h0100,
          {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0180, 16'h0100, 16'h7FFF},
          16'h7FFF, 1'b1, 10, 1'b1, 1'b0);

    train("load_while_busy", 8'b1000_0000, 16'h0000, 16'h0100, 16'h0080,
          {16'hFF80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0180, 16'h0100, 16'h7FFF},
          16'h7F7F, 1'b0, 10, 1'b0, 1'b1);

    load(4'd8, 16'h0042);
    load(4'd9, 16'h7777);
    load(4'd15, 16'h7777);
    @(negedge clk);
    chk("bias_load", bus.bias, 16'h0042);
    chk("bad_addr_weights", bus.weights,
        {16'hFF80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0180, 16'h0100, 16'h7FFF});

    load(4'd5, 16'h8100);
    train("neg_clamp", 8'b0010_0000, 16'h8000, 16'h7FFF, 16'h7FFF,
          {16'hFF80, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0180, 16'h0100, 16'h7FFF},
          16'h8042, 1'b1, 10, 1'b0, 1'b0);

    // Reset in the middle of an update: nothing pushed, so any done is flagged.
    @(negedge clk);
    bus.train_valid = 1'b1; bus.x = 8'hFF; bus.expected_y = 16'h0100; bus.y = 16'h0000;
    bus.learning_rate = 16'h0100;
    @(posedge clk); #1;
    bus.train_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_update", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("reset_mid_update");
    repeat (15) @(negedge clk);
    chk("still_idle_after_abort", bus.busy, 1'b0);

    for (int i = 0; i < 4; i++) load(4'($urandom_range(0, 8)), 16'($urandom));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("reset_after_loads");

    train("basic_after_reset", 8'b0000_0101, 16'h0100, 16'h0000, 16'h0080,
          {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0, 16'h0080},
          16'h0080, 1'b0, 10, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
